// File: rtl/vga_register_scanner.sv
// Purpose : 640x480@60 VGA scan initiator for the register display. Generates
//           x/y counts, per-row register index/value/centre for the renderer,
//           and registers its show return into rgb plus hsync/vsync.
// Latency : hsync/vsync/rgb lag x/y by one enabled cycle; frame_start is a
//           one-clk pulse at the edge that takes the register snapshot.
// Backpressure: none; pix_en gates all scan state, which holds while it is low.
//
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   pix_en          pixel-clock enable
//   reg_flat        16 x 16-bit CPU registers, register i at [16i+15:16i]
//   show            renderer pixel-on, combinational from the outputs below
//   x, y            current scan position
//   center_x/_y     renderer centre for the current register row
//   register_index  register on the current row
//   register_value  frame-stable snapshot of that register
//   hsync, vsync    active-low syncs, registered
//   rgb             registered pixel colour
//   frame_start     one-clk pulse when the snapshot is taken
module vga_register_scanner #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          Y_TOP     = 40,
  parameter int          ROW_PITCH = 24,
  parameter int          X_CENTER  = 320,
  parameter logic [7:0]  FG_COLOR  = 8'hFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_en,
  input  logic [255:0] reg_flat,
  input  logic         show,
  output logic [10:0]  x,
  output logic [10:0]  y,
  output logic [10:0]  center_x,
  output logic [10:0]  center_y,
  output logic [3:0]   register_index,
  output logic [15:0]  register_value,
  output logic         hsync,
  output logic         vsync,
  output logic [7:0]   rgb,
  output logic         frame_start
);

  localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST   = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] HS_BEG   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_BEG   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [10:0] H_VIS_W  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_W  = 11'(V_VISIBLE);
  localparam logic [10:0] TBL_BEG  = 11'(Y_TOP);
  localparam logic [10:0] TBL_END  = 11'(Y_TOP + 16 * ROW_PITCH);
  localparam logic [10:0] PITCH_W  = 11'(ROW_PITCH);
  localparam logic [10:0] CY0      = 11'(Y_TOP + ROW_PITCH / 2);
  localparam logic [10:0] XC_W     = 11'(X_CENTER);

  logic [10:0]  x_q, x_d;
  logic [10:0]  y_q, y_d;
  logic [3:0]   row_q, row_d;
  logic [10:0]  line_q, line_d;
  logic [255:0] shadow_q, shadow_d;
  logic         hsync_q, hsync_d;
  logic         vsync_q, vsync_d;
  logic [7:0]   rgb_q, rgb_d;
  logic         frame_start_q, frame_start_d;

  logic         line_end;
  logic         frame_end;
  logic         in_table;
  logic [10:0]  y_next;

  assign line_end  = (x_q == H_LAST);
  assign frame_end = line_end && (y_q == V_LAST);
  assign in_table  = (y_q >= TBL_BEG) && (y_q < TBL_END);
  assign y_next    = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    row_d         = row_q;
    line_d        = line_q;
    shadow_d      = shadow_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    // Pulse lasts one clk even if pix_en drops right after the boundary.
    frame_start_d = 1'b0;

    if (pix_en) begin
      x_d     = line_end ? 11'd0 : x_q + 11'd1;
      hsync_d = !((x_q >= HS_BEG) && (x_q <= HS_END));
      vsync_d = !((y_q >= VS_BEG) && (y_q <= VS_END));
      rgb_d   = ((x_q < H_VIS_W) && (y_q < V_VIS_W) && in_table && show)
                ? FG_COLOR : 8'h00;

      if (line_end) begin
        y_d = y_next;
        // Row tracking by counting lines, so no divide by ROW_PITCH is needed.
        if (y_next == TBL_BEG) begin
          row_d  = 4'd0;
          line_d = 11'd0;
        end else if (in_table) begin
          if (line_q == PITCH_W - 11'd1) begin
            line_d = 11'd0;
            // Row 15 holds past the table so the outputs keep the last row.
            if (row_q != 4'd15) begin
              row_d = row_q + 4'd1;
            end
          end else begin
            line_d = line_q + 11'd1;
          end
        end
      end

      if (frame_end) begin
        shadow_d      = reg_flat;
        frame_start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q           <= 11'd0;
      y_q           <= 11'd0;
      row_q         <= 4'd0;
      line_q        <= 11'd0;
      shadow_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      row_q         <= row_d;
      line_q        <= line_d;
      shadow_q      <= shadow_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x              = x_q;
  assign y              = y_q;
  assign center_x       = XC_W;
  assign center_y       = CY0 + 11'(row_q) * PITCH_W;
  assign register_index = row_q;
  assign register_value = shadow_q[{row_q, 4'b0000} +: 16];
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign rgb            = rgb_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_register_scanner.sv
// Bench for vga_register_scanner: a reduced-geometry instance checked every
// cycle against a reference model through an expected-output queue, plus a
// default-geometry instance checked over its first line.
module tb_vga_register_scanner;

  // Reduced geometry so whole frames fit in a short run.
  localparam int HV = 16, HF = 2, HS = 4, HB = 2;
  localparam int VV = 40, VF = 2, VS = 2, VB = 2;
  localparam int YT = 4, RP = 2, XC = 8;
  localparam logic [7:0] FG = 8'hA5;
  localparam int HT = HV + HF + HS + HB;   // 24
  localparam int VT = VV + VF + VS + VB;   // 46
  localparam int FR = HT * VT;             // 1104
  localparam int ROW3_Y = YT + 3 * RP;     // 10

  typedef struct packed {
    logic [10:0] x, y, cx, cy;
    logic [3:0]  idx;
    logic [15:0] val;
    logic        hs, vs;
    logic [7:0]  rgb;
    logic        fs;
  } obs_t;

  typedef struct {
    int cycles;
    bit alt;
    bit fshow;
    bit pat;
    int exp_fs;
    int exp_hl;
    int exp_vl;
    int exp_lit;
  } phase_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pix_en = 1'b0;
  logic [255:0] reg_flat = '0;
  logic         show;
  logic         show_force = 1'b0;
  logic         show_pat = 1'b0;
  logic [10:0]  x, y, center_x, center_y;
  logic [3:0]   register_index;
  logic [15:0]  register_value;
  logic         hsync, vsync, frame_start;
  logic [7:0]   rgb;

  // Default-geometry instance signals.
  logic         d_rst = 1'b0;
  logic         d_en = 1'b1;
  logic [255:0] d_reg = '0;
  logic         d_show = 1'b0;
  logic [10:0]  d_x, d_y, d_cx, d_cy;
  logic [3:0]   d_idx;
  logic [15:0]  d_val;
  logic         d_hs, d_vs, d_fs;
  logic [7:0]   d_rgb;

  // Stand-in renderer: lit everywhere when forced, else a checker pattern.
  assign show = show_force | (show_pat & (x[0] ^ y[2]));

  always #5 clk = ~clk;

  vga_register_scanner #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .Y_TOP(YT), .ROW_PITCH(RP), .X_CENTER(XC), .FG_COLOR(FG)
  ) u_dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .reg_flat(reg_flat), .show(show),
    .x(x), .y(y), .center_x(center_x), .center_y(center_y),
    .register_index(register_index), .register_value(register_value),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
  );

  vga_register_scanner u_def (
    .clk(clk), .rst(d_rst), .pix_en(d_en), .reg_flat(d_reg), .show(d_show),
    .x(d_x), .y(d_y), .center_x(d_cx), .center_y(d_cy),
    .register_index(d_idx), .register_value(d_val),
    .hsync(d_hs), .vsync(d_vs), .rgb(d_rgb), .frame_start(d_fs)
  );

  // Reference model state.
  int           mx = 0, my = 0, mrow = 0;
  logic         mhs = 1'b1, mvs = 1'b1, mfs = 1'b0;
  logic [7:0]   mrgb = 8'h00;
  logic [255:0] msh = '0;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, req);
  endtask

  function automatic bit in_tbl(input int yy);
    return (yy >= YT) && (yy < YT + 16 * RP);
  endfunction

  task automatic model_update(input logic en, input logic rstn, input logic s,
                              input logic [255:0] rf);
    if (!rstn) begin
      mx = 0; my = 0; mrow = 0; msh = '0;
      mhs = 1'b1; mvs = 1'b1; mrgb = 8'h00; mfs = 1'b0;
    end else begin
      mfs = 1'b0;
      if (en) begin
        mrgb = (mx < HV && my < VV && in_tbl(my) && s) ? FG : 8'h00;
        mhs  = !(mx >= HV + HF && mx < HV + HF + HS);
        mvs  = !(my >= VV + VF && my < VV + VF + VS);
        if (mx == HT - 1 && my == VT - 1) begin
          mfs = 1'b1;
          msh = rf;
        end
        mx = mx + 1;
        if (mx == HT) begin
          mx = 0;
          my = (my + 1) % VT;
        end
        if (in_tbl(my)) mrow = (my - YT) / RP;
      end
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.x   = 11'(mx);
    o.y   = 11'(my);
    o.cx  = 11'(XC);
    o.cy  = 11'(YT + mrow * RP + RP / 2);
    o.idx = 4'(mrow);
    o.val = msh[mrow * 16 +: 16];
    o.hs  = mhs;
    o.vs  = mvs;
    o.rgb = mrgb;
    o.fs  = mfs;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x = x; o.y = y; o.cx = center_x; o.cy = center_y;
    o.idx = register_index; o.val = register_value;
    o.hs = hsync; o.vs = vsync; o.rgb = rgb; o.fs = frame_start;
    return o;
  endfunction

  // One clk: drive inputs, predict at the falling edge, compare after rising edge.
  task automatic step(input logic en, input logic rstn);
    obs_t e;
    obs_t a;
    pix_en = en;
    rst    = rstn;
    @(negedge clk);
    model_update(en, rstn, show, reg_flat);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = dut_obs();
    checks++;
    if (a === e) passed++;
    else $display("FAIL scoreboard t=%0t got %h want %h", $time, a, e);
  endtask

  task automatic run_to(input int tx, input int ty, input string nm);
    int n;
    n = 0;
    while (!(mx == tx && my == ty) && n < 3 * FR) begin
      step(1'b1, 1'b1);
      n++;
    end
    checks++;
    if (n < 3 * FR) passed++;
    else $display("FAIL %s: position (%0d,%0d) not reached, want (%0d,%0d)", nm, mx, my, tx, ty);
  endtask

  initial begin
    phase_t ph[4];
    int first_low, low_cnt;
    int fs_n, hl_n, vl_n, lit_n;

    ph[0] = '{FR,     1'b0, 1'b0, 1'b0, 1, 184, 48,   0};
    ph[1] = '{2 * FR, 1'b1, 1'b0, 1'b0, 1, 368, 96,   0};
    ph[2] = '{FR,     1'b0, 1'b1, 1'b0, 1, 184, 48, 512};
    ph[3] = '{FR,     1'b0, 1'b0, 1'b1, 1, 184, 48, 256};

    // ---- Default-geometry instance: reset state and first-line hsync.
    d_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("def_reset_x", 32'(d_x), 32'd0);
    chk("def_reset_y", 32'(d_y), 32'd0);
    chk("def_reset_hsync", 32'(d_hs), 32'd1);
    chk("def_reset_vsync", 32'(d_vs), 32'd1);
    chk("def_reset_rgb", 32'(d_rgb), 32'd0);
    chk("def_reset_fs", 32'(d_fs), 32'd0);
    chk("def_center_x", 32'(d_cx), 32'd320);
    chk("def_center_y_row0", 32'(d_cy), 32'd52);
    chk("def_reset_value", 32'(d_val), 32'd0);
    d_rst = 1'b1;
    first_low = -1;
    low_cnt = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      if (!d_hs) begin
        if (first_low < 0) first_low = int'(d_x);
        low_cnt++;
      end
    end
    chk("def_hsync_first_low_x", 32'(first_low), 32'd657);
    chk("def_hsync_low_count", 32'(low_cnt), 32'd96);
    chk("def_vsync_line0", 32'(d_vs), 32'd1);
    chk("def_wrap_x", 32'(d_x), 32'd0);
    chk("def_wrap_y", 32'(d_y), 32'd1);

    // ---- Reduced instance: reset, then table-driven whole-frame phases.
    reg_flat = '0;
    reg_flat[3*16 +: 16] = 16'h1234;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("reset_x", 32'(x), 32'd0);
    chk("reset_hsync", 32'(hsync), 32'd1);
    chk("reset_value", 32'(register_value), 32'd0);

    for (int p = 0; p < 4; p++) begin
      show_force = ph[p].fshow;
      show_pat   = ph[p].pat;
      fs_n = 0; hl_n = 0; vl_n = 0; lit_n = 0;
      for (int c = 0; c < ph[p].cycles; c++) begin
        step(ph[p].alt ? logic'(c % 2 == 0) : 1'b1, 1'b1);
        if (frame_start) fs_n++;
        if (!hsync) hl_n++;
        if (!vsync) vl_n++;
        if (rgb == FG) lit_n++;
      end
      chk($sformatf("phase%0d_frame_start", p), 32'(fs_n), 32'(ph[p].exp_fs));
      chk($sformatf("phase%0d_hsync_low", p), 32'(hl_n), 32'(ph[p].exp_hl));
      chk($sformatf("phase%0d_vsync_low", p), 32'(vl_n), 32'(ph[p].exp_vl));
      chk($sformatf("phase%0d_lit", p), 32'(lit_n), 32'(ph[p].exp_lit));
      chk($sformatf("phase%0d_end_pos", p), 32'({x, y}), 32'd0);
    end
    show_force = 1'b0;
    show_pat   = 1'b0;

    // ---- Row 3 value, and a mid-frame register change held off.
    run_to(0, 5, "seq_a_y5");
    reg_flat[3*16 +: 16] = 16'hBEEF;
    run_to(0, ROW3_Y, "seq_a_row3");
    chk("row3_index", 32'(register_index), 32'd3);
    chk("row3_value_old", 32'(register_value), 32'h1234);
    chk("row3_center_y", 32'(center_y), 32'(YT + 3 * RP + RP / 2));
    run_to(HT - 1, VT - 1, "seq_a_boundary");
    step(1'b1, 1'b1);
    chk("seq_a_frame_start", 32'(frame_start), 32'd1);
    run_to(0, ROW3_Y, "seq_a_row3_next");
    chk("row3_value_new", 32'(register_value), 32'hBEEF);

    // ---- pix_en low on the boundary defers the snapshot.
    run_to(HT - 1, VT - 1, "seq_b_boundary");
    reg_flat[3*16 +: 16] = 16'h5A5A;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("deferred_no_pulse", 32'(frame_start), 32'd0);
    chk("deferred_hold_x", 32'(x), 32'(HT - 1));
    step(1'b1, 1'b1);
    chk("deferred_pulse", 32'(frame_start), 32'd1);
    chk("deferred_wrap", 32'({x, y}), 32'd0);
    run_to(0, ROW3_Y, "seq_b_row3");
    chk("deferred_value", 32'(register_value), 32'h5A5A);

    // ---- Reset mid-frame, then forced-show table edges.
    run_to(10, 25, "seq_c_mid");
    show_force = 1'b1;
    step(1'b1, 1'b0);
    chk("midrst_pos", 32'({x, y}), 32'd0);
    chk("midrst_syncs", 32'({hsync, vsync}), 32'd3);
    chk("midrst_rgb", 32'(rgb), 32'd0);
    chk("midrst_value", 32'(register_value), 32'd0);
    run_to(1, YT - 1, "seq_c_above");
    chk("rgb_above_table", 32'(rgb), 32'd0);
    run_to(1, YT, "seq_c_first");
    chk("rgb_table_first", 32'(rgb), 32'(FG));
    run_to(HV, YT, "seq_c_lastcol");
    chk("rgb_last_visible_x", 32'(rgb), 32'(FG));
    step(1'b1, 1'b1);
    chk("rgb_first_blank_x", 32'(rgb), 32'd0);
    run_to(1, YT + 16 * RP, "seq_c_below");
    chk("rgb_below_table", 32'(rgb), 32'd0);
    chk("below_table_row_held", 32'(register_index), 32'd15);
    show_force = 1'b0;
    repeat (50) step(1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
